// File: rtl/dt_seq_pkg.sv
// Shared types for the D/T flip-flop command sequencer: op codes, FSM state, op-to-drive mapping.
package dt_seq_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_TOGGLE = 2'b01,
    OP_LOAD0  = 2'b10,
    OP_LOAD1  = 2'b11
  } op_e;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_ISSUE = 1'b1;

  // Returns {ff_sel, ff_d} for an op.
  function automatic logic [1:0] op_to_drive(input op_e op);
    logic [1:0] drv;
    drv = 2'b00;
    case (op)
      OP_HOLD:   drv = 2'b00;
      OP_TOGGLE: drv = 2'b01;
      OP_LOAD0:  drv = 2'b10;
      OP_LOAD1:  drv = 2'b11;
      default:   drv = 2'b00;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/dt_cmd_sequencer_if.sv
// Command handshake and flip-flop drive bundle; exp_q exists only with DT_SEQ_TRACK_EN.
interface dt_cmd_sequencer_if
  import dt_seq_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int DEPTH = 4
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  op_e                      cmd_op;
  logic [CNT_W-1:0]         cmd_cnt;
  logic                     ff_d;
  logic                     ff_sel;
  logic                     busy;
  logic                     done;
  logic [$clog2(DEPTH):0]   fifo_level;
`ifdef DT_SEQ_TRACK_EN
  logic                     exp_q;

  modport master (output cmd_valid, cmd_op, cmd_cnt,
                  input  cmd_ready, ff_d, ff_sel, busy, done, fifo_level, exp_q);
  modport slave  (input  cmd_valid, cmd_op, cmd_cnt,
                  output cmd_ready, ff_d, ff_sel, busy, done, fifo_level, exp_q);
`else
  modport master (output cmd_valid, cmd_op, cmd_cnt,
                  input  cmd_ready, ff_d, ff_sel, busy, done, fifo_level);
  modport slave  (input  cmd_valid, cmd_op, cmd_cnt,
                  output cmd_ready, ff_d, ff_sel, busy, done, fifo_level);
`endif
endinterface

// File: rtl/dt_cmd_fifo.sv
// Synchronous command FIFO, DEPTH a power of two; pushes are ignored when full, pops when empty.
// Read data is the registered head entry, valid whenever !empty.
module dt_cmd_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dt_cmd_sequencer.sv
// Replays buffered hold/toggle/load commands as registered {ff_sel, ff_d} beats; first beat 2 cycles after push.
// cmd_ready = !fifo_full; back-to-back commands run gap-free. DT_SEQ_TRACK_EN adds exp_q reference model.
module dt_cmd_sequencer
  import dt_seq_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  dt_cmd_sequencer_if.slave   bus
);
  typedef struct packed {
    op_e              op;
    logic [CNT_W-1:0] cnt;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  cmd_t                   cmd_in;
  cmd_t                   head;
  logic                   fifo_full, fifo_empty, pop;
  logic [$clog2(DEPTH):0] level;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       drv_q, drv_d;
  logic             done_q, done_d;

  assign cmd_in = '{op: bus.cmd_op, cnt: bus.cmd_cnt};

  dt_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cmd_valid),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    drv_d   = drv_q;
    pop     = 1'b0;
    if (state_q == ST_ISSUE && rem_q != '0) begin
      rem_d = rem_q - CNT_W'(1);
    end else if (!fifo_empty) begin
      // Idle or on the last beat: chain straight into the next command.
      pop     = 1'b1;
      state_d = ST_ISSUE;
      drv_d   = op_to_drive(head.op);
      rem_d   = head.cnt;
    end else begin
      state_d = ST_IDLE;
      drv_d   = op_to_drive(OP_HOLD);
      rem_d   = '0;
    end
    done_d = (state_d == ST_ISSUE) && (rem_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      drv_q   <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      drv_q   <= drv_d;
      done_q  <= done_d;
    end
  end

  assign bus.cmd_ready  = !fifo_full;
  assign bus.ff_sel     = drv_q[1];
  assign bus.ff_d       = drv_q[0];
  assign bus.done       = done_q;
  assign bus.busy       = (state_q == ST_ISSUE) || !fifo_empty;
  assign bus.fifo_level = level;

`ifdef DT_SEQ_TRACK_EN
  logic exp_q, exp_d;

  always_comb begin
    exp_d = exp_q;
    case (drv_q)
      2'b10, 2'b11: exp_d = drv_q[0];
      2'b01:        exp_d = ~exp_q;
      default:      exp_d = exp_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) exp_q <= 1'b0;
    else     exp_q <= exp_d;
  end

  assign bus.exp_q = exp_q;
`endif

endmodule

// File: tb/tb_dt_cmd_sequencer.sv
// Directed bench for dt_cmd_sequencer: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_dt_cmd_sequencer;
  import dt_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  dt_cmd_sequencer_if #(.CNT_W(4), .DEPTH(4)) bus ();

  dt_cmd_sequencer #(.CNT_W(4), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    op_e        op;
    logic [3:0] cnt;
    logic [1:0] drv;
    logic       done;
    logic       busy;
    logic [2:0] lvl;
    logic       rdy;
  } vec_t;

  vec_t vt[11];

  logic [1:0] mon_q[$];
  int         mon_dones;
  logic       mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if ({bus.ff_sel, bus.ff_d} != 2'b00) mon_q.push_back({bus.ff_sel, bus.ff_d});
      if (bus.done) mon_dones++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_HOLD;
    bus.cmd_cnt   = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Holds the command until accepted; waited = edges that did not take it.
  task automatic push_cmd(input op_e op, input logic [3:0] cnt, output int waited);
    logic acc;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_cnt   = cnt;
    waited        = 0;
    forever begin
      acc = bus.cmd_ready;
      tick();
      if (acc) break;
      waited++;
      if (waited > 100) begin
        chk("push_timeout", waited, 0);
        break;
      end
    end
    bus.cmd_valid = 1'b0;
  endtask

  function automatic int drv();
    return {bus.ff_sel, bus.ff_d};
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int         w;
    int         beats, dones, done_beat, nd;
    logic [1:0] exp_seq[$];

    // Single command then back-to-back chain: inputs before edge i, outputs after it.
    vt[0]  = '{1'b1, OP_LOAD1,  4'd0, 2'b00, 1'b0, 1'b1, 3'd1, 1'b1};
    vt[1]  = '{1'b0, OP_HOLD,   4'd0, 2'b11, 1'b1, 1'b1, 3'd0, 1'b1};
    vt[2]  = '{1'b0, OP_HOLD,   4'd0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1};
    vt[3]  = '{1'b1, OP_LOAD0,  4'd1, 2'b00, 1'b0, 1'b1, 3'd1, 1'b1};
    vt[4]  = '{1'b1, OP_TOGGLE, 4'd0, 2'b10, 1'b0, 1'b1, 3'd1, 1'b1};
    vt[5]  = '{1'b1, OP_LOAD1,  4'd2, 2'b10, 1'b1, 1'b1, 3'd2, 1'b1};
    vt[6]  = '{1'b0, OP_HOLD,   4'd0, 2'b01, 1'b1, 1'b1, 3'd1, 1'b1};
    vt[7]  = '{1'b0, OP_HOLD,   4'd0, 2'b11, 1'b0, 1'b1, 3'd0, 1'b1};
    vt[8]  = '{1'b0, OP_HOLD,   4'd0, 2'b11, 1'b0, 1'b1, 3'd0, 1'b1};
    vt[9]  = '{1'b0, OP_HOLD,   4'd0, 2'b11, 1'b1, 1'b1, 3'd0, 1'b1};
    vt[10] = '{1'b0, OP_HOLD,   4'd0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1};

    do_reset();
    chk("rst_drv",   drv(), 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_ready", bus.cmd_ready, 1);
`ifdef DT_SEQ_TRACK_EN
    chk("rst_exp_q", bus.exp_q, 0);
`endif

    for (int i = 0; i < 11; i++) begin
      bus.cmd_valid = vt[i].vld;
      bus.cmd_op    = vt[i].op;
      bus.cmd_cnt   = vt[i].cnt;
      tick();
      chk($sformatf("vec%0d_drv", i),   drv(),          vt[i].drv);
      chk($sformatf("vec%0d_done", i),  bus.done,       vt[i].done);
      chk($sformatf("vec%0d_busy", i),  bus.busy,       vt[i].busy);
      chk($sformatf("vec%0d_level", i), bus.fifo_level, vt[i].lvl);
      chk($sformatf("vec%0d_ready", i), bus.cmd_ready,  vt[i].rdy);
    end
    bus.cmd_valid = 1'b0;

    // Repeated toggle with reference model.
    do_reset();
    push_cmd(OP_TOGGLE, 4'd3, w);
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("tog_beat%0d_drv", k),  drv(),    1);
      chk($sformatf("tog_beat%0d_done", k), bus.done, (k == 4) ? 1 : 0);
`ifdef DT_SEQ_TRACK_EN
      chk($sformatf("tog_beat%0d_exp_q", k), bus.exp_q, (k - 1) % 2);
`endif
      tick();
    end
    chk("tog_after_drv",  drv(),    0);
    chk("tog_after_busy", bus.busy, 0);
`ifdef DT_SEQ_TRACK_EN
    chk("tog_after_exp_q", bus.exp_q, 0);
`endif

    // Full FIFO with a held sixth command.
    do_reset();
    mon_q.delete();
    mon_dones = 0;
    mon_en    = 1'b1;
    push_cmd(OP_LOAD1,  4'd15, w);
    push_cmd(OP_LOAD0,  4'd0,  w);
    push_cmd(OP_TOGGLE, 4'd0,  w);
    push_cmd(OP_LOAD1,  4'd0,  w);
    push_cmd(OP_LOAD0,  4'd1,  w);
    chk("full_level", bus.fifo_level, 4);
    chk("full_ready", bus.cmd_ready, 0);
    push_cmd(OP_TOGGLE, 4'd0, w);
    chk("full_held_wait", w, 13);
    chk("full_level_after_accept", bus.fifo_level, 3);
    for (int k = 0; k < 100 && bus.busy; k++) tick();
    chk("full_drain_busy", bus.busy, 0);
    mon_en = 1'b0;
    exp_seq.delete();
    for (int k = 0; k < 16; k++) exp_seq.push_back(2'b11);
    exp_seq.push_back(2'b10);
    exp_seq.push_back(2'b01);
    exp_seq.push_back(2'b11);
    exp_seq.push_back(2'b10);
    exp_seq.push_back(2'b10);
    exp_seq.push_back(2'b01);
    chk("full_beat_count", mon_q.size(), exp_seq.size());
    chk("full_done_count", mon_dones, 6);
    nd = 0;
    for (int k = 0; k < exp_seq.size() && k < mon_q.size(); k++)
      if (mon_q[k] != exp_seq[k]) nd++;
    chk("full_beat_order_mismatches", nd, 0);

    // Reset during beat 3 of a long toggle with two commands queued.
    do_reset();
    push_cmd(OP_TOGGLE, 4'd7, w);
    push_cmd(OP_LOAD1,  4'd0, w);
    push_cmd(OP_LOAD0,  4'd0, w);
    tick();
    chk("midrst_beat3_drv",   drv(), 1);
    chk("midrst_beat3_level", bus.fifo_level, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_drv",   drv(), 0);
    chk("midrst_level", bus.fifo_level, 0);
    chk("midrst_busy",  bus.busy, 0);
    chk("midrst_done",  bus.done, 0);
    chk("midrst_ready", bus.cmd_ready, 1);
`ifdef DT_SEQ_TRACK_EN
    chk("midrst_exp_q", bus.exp_q, 0);
`endif
    nd = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.done || drv() != 0) nd++;
    end
    chk("midrst_quiet_cycles", nd, 0);
    push_cmd(OP_LOAD1, 4'd0, w);
    chk("midrst_replay_lat1_drv", drv(), 0);
    chk("midrst_replay_level", bus.fifo_level, 1);
    tick();
    chk("midrst_replay_lat2_drv",  drv(), 3);
    chk("midrst_replay_lat2_done", bus.done, 1);

    // Maximum repeat count.
    do_reset();
    push_cmd(OP_TOGGLE, 4'd15, w);
    beats = 0;
    dones = 0;
    done_beat = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (drv() == 1) beats++;
      if (bus.done) begin
        dones++;
        done_beat = beats;
      end
    end
    chk("max_beats", beats, 16);
    chk("max_dones", dones, 1);
    chk("max_done_on_last", done_beat, 16);
    chk("max_end_busy", bus.busy, 0);
    chk("max_end_drv", drv(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
